// File: rtl/spc_node_seq.sv
// Multi-beat single-parity-check node sequencer: buffers hard decisions of an
// 8..64-LLR SPC node, flips the least-reliable bit on odd parity, streams the result.
// Optional status outputs (par_err, flip_idx) are enabled by defining SPC_NODE_STATUS_EN.
module spc_node_seq #(
    parameter int LLR_W   = 6,
    parameter int MAX_LEN = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         len_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*LLR_W-1:0] in_llr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_bits,
    output logic               busy,
    output logic               done
`ifdef SPC_NODE_STATUS_EN
    ,
    output logic               par_err,
    output logic [5:0]         flip_idx
`endif
);

    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam int BEAT_W = IDX_W - 2;
    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
    localparam logic [LLR_W-1:0]  LLR_ONE  = LLR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLIP,
        OUT
    } state_t;

    state_t               state, state_n;
    logic [BEAT_W-1:0]    beat_cnt, cnt_n;
    logic [BEAT_W-1:0]    last_beat, last_n;
    logic                 parity, parity_n;
    logic [MAX_LEN-1:0]   bit_buf, buf_n;
    logic [LLR_W-1:0]     min_abs, min_abs_n;
    logic [IDX_W-1:0]     min_idx, min_idx_n;
    logic [3:0]           out_bits_n;
    logic                 done_n;

    logic [LLR_W-1:0]     lane_llr [4];
    logic [LLR_W-1:0]     lane_abs [4];
    logic [LLR_W-1:0]     bmin_abs;
    logic [1:0]           bmin_lane;

    // Unsigned magnitude; the most negative code maps to the largest magnitude.
    function automatic logic [LLR_W-1:0] llr_abs(input logic [LLR_W-1:0] x);
        return x[LLR_W-1] ? ((~x) + LLR_ONE) : x;
    endfunction

    // In-beat minimum: strict compare while scanning upward keeps the lower lane on ties.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            lane_llr[j] = in_llr[(3-j)*LLR_W +: LLR_W];
            lane_abs[j] = llr_abs(lane_llr[j]);
        end
        bmin_abs  = lane_abs[0];
        bmin_lane = 2'd0;
        for (int j = 1; j < 4; j++) begin
            if (lane_abs[j] < bmin_abs) begin
                bmin_abs  = lane_abs[j];
                bmin_lane = 2'(j);
            end
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_n   = state;
        cnt_n     = beat_cnt;
        last_n    = last_beat;
        parity_n  = parity;
        buf_n     = bit_buf;
        min_abs_n = min_abs;
        min_idx_n = min_idx;
        done_n    = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n   = LOAD;
                    cnt_n     = '0;
                    parity_n  = 1'b0;
                    buf_n     = '0;
                    min_abs_n = '1;
                    min_idx_n = '0;
                    unique case (len_sel)
                        2'd0: last_n = BEAT_W'(1);
                        2'd1: last_n = BEAT_W'(3);
                        2'd2: last_n = BEAT_W'(7);
                        default: last_n = BEAT_W'(15);
                    endcase
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    for (int j = 0; j < 4; j++) begin
                        buf_n[{beat_cnt, 2'(j)}] = lane_llr[j][LLR_W-1];
                        parity_n = parity_n ^ lane_llr[j][LLR_W-1];
                    end
                    // Strict compare across beats: the earliest beat keeps a tied minimum.
                    if (bmin_abs < min_abs) begin
                        min_abs_n = bmin_abs;
                        min_idx_n = {beat_cnt, bmin_lane};
                    end
                    if (beat_cnt == last_beat) begin
                        state_n = FLIP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = beat_cnt + BEAT_ONE;
                    end
                end
            end
            FLIP: begin
                if (parity) begin
                    buf_n[min_idx] = ~bit_buf[min_idx];
                end
                state_n = OUT;
            end
            OUT: begin
                if (out_valid && out_ready) begin
                    if (beat_cnt == last_beat) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = beat_cnt + BEAT_ONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Output beat is precomputed from next-cycle buffer/counter so out_bits is registered.
        out_bits_n = 4'b0000;
        if (state_n == OUT) begin
            out_bits_n = {buf_n[{cnt_n, 2'd0}], buf_n[{cnt_n, 2'd1}],
                          buf_n[{cnt_n, 2'd2}], buf_n[{cnt_n, 2'd3}]};
        end
    end

    // NOTE: the bit buffer is a flop array, not RAM, so it is cleared by reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            last_beat <= '0;
            parity    <= 1'b0;
            bit_buf   <= '0;
            min_abs   <= '1;
            min_idx   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_bits  <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state     <= state_n;
            beat_cnt  <= cnt_n;
            last_beat <= last_n;
            parity    <= parity_n;
            bit_buf   <= buf_n;
            min_abs   <= min_abs_n;
            min_idx   <= min_idx_n;
            in_ready  <= (state_n == LOAD);
            out_valid <= (state_n == OUT);
            out_bits  <= out_bits_n;
            busy      <= (state_n != IDLE);
            done      <= done_n;
        end
    end

`ifdef SPC_NODE_STATUS_EN
    // Captured with the last input beat so the status is visible from the FLIP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err  <= 1'b0;
            flip_idx <= '0;
        end else if (state == LOAD && state_n == FLIP) begin
            par_err  <= parity_n;
            flip_idx <= min_idx_n;
        end
    end
`else
    // Status outputs absent in this build.
`endif

endmodule
